// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises valid/ready bitstream words onto a configuration flop chain.
// Define CCFF_READBACK_EN to add rd_* ports returning the bits that leave the chain on ccff_tail.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 24,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 5
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
`ifdef CCFF_READBACK_EN
  ,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready
`endif
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WORD_W-1:0] r_shreg;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_total;
  logic              r_busy;
  logic              r_done;
  logic              w_accept;
  logic              w_start_ok;
  logic              w_last_bit;
  logic              w_word_end;
  logic              w_stall;
  logic              w_fin;
  logic              w_drain_ok;

  assign w_accept   = (r_state == S_LOAD) && cfg_valid;
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last_bit = (r_total == CNT_W'(CHAIN_LEN - 1));
  assign w_word_end = (r_idx == IDX_W'(WORD_W - 1));

`ifdef CCFF_READBACK_EN
  // After the final shift the FSM lingers in SHIFT until the last readback word drains.
  localparam state_t FINAL_STATE = S_SHIFT;

  logic [WORD_W-1:0] r_rd_sh;
  logic [WORD_W-1:0] r_rd_data;
  logic [WORD_W-1:0] w_rd_word;
  logic [IDX_W-1:0]  r_rd_cnt;
  logic              r_rd_valid;
  logic              w_rd_emit;

  assign w_rd_emit  = (r_rd_cnt == IDX_W'(WORD_W - 1)) || w_last_bit;
  assign w_rd_word  = r_rd_sh | (WORD_W'(ccff_tail) << r_rd_cnt);
  assign w_stall    = r_rd_valid && !rd_ready && w_rd_emit;
  assign w_fin      = (r_total == CNT_W'(CHAIN_LEN));
  assign w_drain_ok = !r_rd_valid || rd_ready;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_rd_sh    <= '0;
      r_rd_cnt   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (r_rd_valid && rd_ready) begin
        r_rd_valid <= 1'b0;
      end
      if (ccff_shift_en) begin
        if (w_rd_emit) begin
          r_rd_data  <= w_rd_word;
          r_rd_valid <= 1'b1;
          r_rd_sh    <= '0;
          r_rd_cnt   <= '0;
        end else begin
          r_rd_sh  <= w_rd_word;
          r_rd_cnt <= r_rd_cnt + IDX_W'(1);
        end
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
`else
  localparam state_t FINAL_STATE = S_DONE;

  logic w_unused_tail;
  assign w_unused_tail = ccff_tail;
  assign w_stall       = 1'b0;
  assign w_fin         = 1'b0;
  assign w_drain_ok    = 1'b1;
`endif

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_LOAD;
      S_LOAD:  if (cfg_valid) w_state_next = S_SHIFT;
      S_SHIFT: begin
        if (w_fin) begin
          if (w_drain_ok) w_state_next = S_DONE;
        end else if (!w_stall) begin
          // Chain length wins over word boundary so a short final word is truncated.
          if (w_last_bit) w_state_next = FINAL_STATE;
          else if (w_word_end) w_state_next = S_LOAD;
        end
      end
      S_DONE:  if (start) w_state_next = S_LOAD;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready     = (r_state == S_LOAD);
    ccff_shift_en = (r_state == S_SHIFT) && !w_fin && !w_stall;
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_shreg <= '0;
      r_idx   <= '0;
      r_total <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (w_state_next == S_LOAD) || (w_state_next == S_SHIFT);
      r_done <= (w_state_next == S_DONE);
      if (w_start_ok) begin
        r_total <= '0;
      end
      if (w_accept) begin
        r_shreg <= cfg_data;
        r_idx   <= '0;
      end else if (ccff_shift_en) begin
        r_shreg <= r_shreg >> 1;
        r_idx   <= r_idx + IDX_W'(1);
        r_total <= r_total + CNT_W'(1);
      end
    end
  end

  assign ccff_head = r_shreg[0];
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: models the config chain, scoreboards head bits and readback words.
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        prog_reset, start, cfg_valid, cfg_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done;
  logic [7:0]  cfg_data;
  logic        start20, valid20, ready20, head20, sen20, tail20, busy20, done20;
  logic [7:0]  data20;
`ifdef CCFF_READBACK_EN
  logic [7:0]  rd_data, rd_data20;
  logic        rd_valid, rd_ready, rd_valid20, rd_ready20;
`endif

  logic [23:0] chain;
  logic [19:0] chain20;
  logic        preload_req;
  logic [23:0] preload_val;

  assign ccff_tail = chain[0];
  assign tail20    = chain20[0];

  always @(posedge clk) begin
    if (preload_req) chain <= preload_val;
    else if (ccff_shift_en) chain <= {ccff_head, chain[23:1]};
  end

  always @(posedge clk) begin
    if (preload_req) chain20 <= '0;
    else if (sen20) chain20 <= {head20, chain20[19:1]};
  end

  ccff_chain_loader #(.CHAIN_LEN(24), .WORD_W(8), .CNT_W(5)) u_dut (
    .prog_clk(clk), .prog_reset(prog_reset), .start(start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .ccff_head(ccff_head),
    .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail), .busy(busy), .done(done)
`ifdef CCFF_READBACK_EN
    , .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready)
`endif
  );

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8), .CNT_W(5)) u_dut20 (
    .prog_clk(clk), .prog_reset(prog_reset), .start(start20), .cfg_data(data20),
    .cfg_valid(valid20), .cfg_ready(ready20), .ccff_head(head20),
    .ccff_shift_en(sen20), .ccff_tail(tail20), .busy(busy20), .done(done20)
`ifdef CCFF_READBACK_EN
    , .rd_data(rd_data20), .rd_valid(rd_valid20), .rd_ready(rd_ready20)
`endif
  );

  int   n_checks = 0;
  int   n_errors = 0;
  int   pulses   = 0;
  int   pulses20 = 0;
  int   acc20    = 0;
  int   base     = 0;
  int   cnt      = 0;
  logic exp_q[$];
  logic exp20_q[$];
`ifdef CCFF_READBACK_EN
  logic [7:0] rd_q[$];
  logic       rd_chk = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Sample DUT outputs on the falling edge, then advance to just after the next rising edge.
  task automatic step();
    logic e;
    @(negedge clk);
    if (ccff_shift_en) begin
      pulses++;
      if (exp_q.size() == 0) check("head_unexpected_pulse", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        check("head_bit", 32'(ccff_head), 32'(e));
      end
    end
    if (sen20) begin
      pulses20++;
      if (exp20_q.size() == 0) check("head20_unexpected_pulse", 32'(exp20_q.size()), 32'd1);
      else begin
        e = exp20_q.pop_front();
        check("head20_bit", 32'(head20), 32'(e));
      end
    end
    if (ready20 && valid20) acc20++;
`ifdef CCFF_READBACK_EN
    if (rd_chk && rd_valid && rd_ready) begin
      if (rd_q.size() == 0) check("rd_unexpected_word", 32'(rd_q.size()), 32'd1);
      else check("rd_word", 32'(rd_data), 32'(rd_q.pop_front()));
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    int n;
    for (int b = 0; b < 8; b++) exp_q.push_back(w[b]);
    cfg_data  = w;
    cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) check("cfg_ready_timeout", 32'(n), 32'd0);
    step();
    check("accept_latency_shift_en", 32'(ccff_shift_en), 32'd1);
    check("accept_first_head", 32'(ccff_head), 32'(w[0]));
  endtask

  task automatic load3(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2, input int gap);
    int n;
    send_word(w0);
    if (gap > 0) begin
      cfg_valid = 1'b0;
      n = 0;
      while (!cfg_ready && n < 60) begin
        step();
        n++;
      end
      for (int g = 0; g < gap; g++) begin
        if (g == 2) start = 1'b1;
        step();
        start = 1'b0;
        check("gap_shift_en", 32'(ccff_shift_en), 32'd0);
        check("gap_cfg_ready", 32'(cfg_ready), 32'd1);
        check("gap_busy", 32'(busy), 32'd1);
      end
    end
    send_word(w1);
    send_word(w2);
    cfg_valid = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      step();
      n++;
    end
    check("load_done", 32'(done), 32'd1);
    check("load_busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    prog_reset  = 1'b1;
    start       = 1'b0;
    cfg_valid   = 1'b0;
    cfg_data    = 8'h00;
    start20     = 1'b0;
    valid20     = 1'b0;
    data20      = 8'h00;
    preload_req = 1'b1;
    preload_val = 24'h0;
`ifdef CCFF_READBACK_EN
    rd_ready   = 1'b1;
    rd_ready20 = 1'b1;
`endif
    @(posedge clk);
    #1;
    step();
    step();
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_head", 32'(ccff_head), 32'd0);
    check("rst_shift_en", 32'(ccff_shift_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
`ifdef CCFF_READBACK_EN
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
`endif
    prog_reset  = 1'b0;
    preload_req = 1'b0;
    step();

    // Scenario 1: three gap-free words.
    start = 1'b1;
    step();
    start = 1'b0;
    check("s1_busy", 32'(busy), 32'd1);
    check("s1_cfg_ready", 32'(cfg_ready), 32'd1);
    base = pulses;
    load3(8'hA5, 8'h3C, 8'hF0, 0);
    check("s1_pulses", 32'(pulses - base), 32'd24);
    check("s1_chain", 32'(chain), 32'hF03CA5);
    check("s1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Scenario 6: done holds while idle; start in DONE restarts.
    preload_val = 24'h0;
    preload_req = 1'b1;
    step();
    preload_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("s6_done_hold", 32'(done), 32'd1);
      check("s6_no_shift", 32'(ccff_shift_en), 32'd0);
    end
    check("s6_no_extra_pulses", 32'(pulses - base), 32'd24);
    start = 1'b1;
    step();
    start = 1'b0;
    check("s6_done_cleared", 32'(done), 32'd0);
    check("s6_cfg_ready", 32'(cfg_ready), 32'd1);

    // Scenario 3: cfg_valid gap before word 2 with an ignored mid-load start.
    base = pulses;
    load3(8'hA5, 8'h3C, 8'hF0, 5);
    check("s3_pulses", 32'(pulses - base), 32'd24);
    check("s3_chain", 32'(chain), 32'hF03CA5);

    // Scenario 4: reset after 10 pulses, then a full reload.
    start = 1'b1;
    step();
    start = 1'b0;
    base = pulses;
    send_word(8'h11);
    send_word(8'h22);
    cnt = 0;
    while ((pulses - base) < 10 && cnt < 60) begin
      step();
      cnt++;
    end
    check("s4_reached_10", 32'(pulses - base), 32'd10);
    prog_reset = 1'b1;
    step();
    check("s4_rst_shift_en", 32'(ccff_shift_en), 32'd0);
    check("s4_rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("s4_rst_busy", 32'(busy), 32'd0);
    check("s4_rst_done", 32'(done), 32'd0);
    check("s4_rst_head", 32'(ccff_head), 32'd0);
    prog_reset = 1'b0;
    cfg_valid  = 1'b0;
    exp_q.delete();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    base = pulses;
    load3(8'h5A, 8'hC3, 8'h81, 0);
    check("s4_pulses", 32'(pulses - base), 32'd24);
    check("s4_chain", 32'(chain), 32'h81C35A);

    // Scenario 2: 20-flop chain, third word truncated to 4 bits.
    for (int k = 0; k < 20; k++) exp20_q.push_back(1'b1);
    data20  = 8'hFF;
    valid20 = 1'b1;
    start20 = 1'b1;
    step();
    start20 = 1'b0;
    cnt = 0;
    while (!done20 && cnt < 100) begin
      step();
      cnt++;
    end
    valid20 = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("s2_done", 32'(done20), 32'd1);
    check("s2_pulses", 32'(pulses20), 32'd20);
    check("s2_words_accepted", 32'(acc20), 32'd3);
    check("s2_chain", 32'(chain20), 32'hFFFFF);

`ifdef CCFF_READBACK_EN
    // Scenario 5: read back a preloaded chain with a consumer stall.
    preload_val = 24'h123456;
    preload_req = 1'b1;
    step();
    preload_req = 1'b0;
    rd_q.push_back(8'h56);
    rd_q.push_back(8'h34);
    rd_q.push_back(8'h12);
    rd_chk   = 1'b1;
    rd_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    base = pulses;
    send_word(8'hA5);
    send_word(8'h3C);
    cnt = 0;
    while ((pulses - base) < 15 && cnt < 60) begin
      step();
      cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      check("s5_stall_shift_en", 32'(ccff_shift_en), 32'd0);
      check("s5_stall_rd_valid", 32'(rd_valid), 32'd1);
      step();
    end
    check("s5_stall_pulses", 32'(pulses - base), 32'd15);
    rd_ready = 1'b1;
    send_word(8'hF0);
    cfg_valid = 1'b0;
    cnt = 0;
    while (!done && cnt < 100) begin
      step();
      cnt++;
    end
    check("s5_done", 32'(done), 32'd1);
    check("s5_pulses", 32'(pulses - base), 32'd24);
    check("s5_chain", 32'(chain), 32'hF03CA5);
    check("s5_rd_all_seen", 32'(rd_q.size()), 32'd0);
    rd_chk = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
